// File: rtl/counter_checker.sv
// counter_checker: aligns expected counter values with DUT outputs, compares them inside a start/stop window and logs mismatches
module counter_checker #(
    parameter int LAT   = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             valid,
    input  logic [3:0]       exp_Q,
    input  logic             exp_rco,
    input  logic [3:0]       dut_Q,
    input  logic             dut_rco,
    output logic [1:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] smp_count,
    output logic [4:0]       first_exp,
    output logic [4:0]       first_dut,
    output logic [CNT_W-1:0] first_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CHECK = 2'b01,
        S_DONE  = 2'b10,
        S_FAIL  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
    logic [4:0]       first_exp_q, first_exp_d;
    logic [4:0]       first_dut_q, first_dut_d;
    logic [CNT_W-1:0] first_idx_q, first_idx_d;

    logic [5:0] cur;
    logic [5:0] dly;
    logic       enter;
    logic       cmp;
    logic       mis;

    assign cur   = {valid, exp_rco, exp_Q};
    assign enter = start && (state_q != S_CHECK);
    assign cmp   = (state_q == S_CHECK) && dly[5];
    assign mis   = cmp && (dly[4:0] != {dut_rco, dut_Q});

    generate
        if (LAT == 0) begin : g_nodly
            assign dly = cur;
        end else begin : g_dly
            logic [5:0] dl_q [LAT];
            // Expected-side delay line; a new window drops every in-flight valid bit
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < LAT; i++) dl_q[i] <= '0;
                end else begin
                    dl_q[0] <= enter ? {1'b0, cur[4:0]} : cur;
                    for (int i = 1; i < LAT; i++)
                        dl_q[i] <= enter ? {1'b0, dl_q[i-1][4:0]} : dl_q[i-1];
                end
            end
            assign dly = dl_q[LAT-1];
        end
    endgenerate

    // Next-state: window entry clears the log, compares update it, stop grades the window
    always_comb begin
        state_d     = state_q;
        err_d       = mis;
        err_cnt_d   = err_cnt_q;
        smp_cnt_d   = smp_cnt_q;
        first_exp_d = first_exp_q;
        first_dut_d = first_dut_q;
        first_idx_d = first_idx_q;
        if (enter) begin
            state_d     = S_CHECK;
            err_cnt_d   = '0;
            smp_cnt_d   = '0;
            first_exp_d = '0;
            first_dut_d = '0;
            first_idx_d = '0;
        end else if (state_q == S_CHECK) begin
            if (cmp)
                smp_cnt_d = (smp_cnt_q == CNT_MAX) ? smp_cnt_q : smp_cnt_q + CNT_W'(1);
            if (mis) begin
                err_cnt_d = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + CNT_W'(1);
                if (err_cnt_q == '0) begin
                    first_exp_d = dly[4:0];
                    first_dut_d = {dut_rco, dut_Q};
                    first_idx_d = smp_cnt_q;
                end
            end
            if (stop)
                state_d = (err_cnt_d == '0) ? S_DONE : S_FAIL;
        end
    end

    // FSM and registered outputs, reset wins over every other input
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            smp_cnt_q   <= '0;
            first_exp_q <= '0;
            first_dut_q <= '0;
            first_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
            first_exp_q <= first_exp_d;
            first_dut_q <= first_dut_d;
            first_idx_q <= first_idx_d;
        end
    end

    assign state     = state_q;
    assign err       = err_q;
    assign err_count = err_cnt_q;
    assign smp_count = smp_cnt_q;
    assign first_exp = first_exp_q;
    assign first_dut = first_dut_q;
    assign first_idx = first_idx_q;

endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: three checker instances (LAT 0/1/2) driven in parallel and compared against a history-based model
module tb_counter_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, stop, valid, exp_rco, dut_rco;
    logic [3:0] exp_Q, dut_Q;

    logic [1:0] o_st [3];
    logic       o_err [3];
    logic [7:0] o_ec [3];
    logic [7:0] o_sc [3];
    logic [7:0] o_fi [3];
    logic [4:0] o_fe [3];
    logic [4:0] o_fd [3];
    logic [3:0] ec2, sc2, fi2;

    assign o_ec[2] = {4'b0, ec2};
    assign o_sc[2] = {4'b0, sc2};
    assign o_fi[2] = {4'b0, fi2};

    counter_checker #(.LAT(0), .CNT_W(8)) u0 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .valid(valid),
        .exp_Q(exp_Q), .exp_rco(exp_rco), .dut_Q(dut_Q), .dut_rco(dut_rco),
        .state(o_st[0]), .err(o_err[0]), .err_count(o_ec[0]), .smp_count(o_sc[0]),
        .first_exp(o_fe[0]), .first_dut(o_fd[0]), .first_idx(o_fi[0]));

    counter_checker #(.LAT(1), .CNT_W(8)) u1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .valid(valid),
        .exp_Q(exp_Q), .exp_rco(exp_rco), .dut_Q(dut_Q), .dut_rco(dut_rco),
        .state(o_st[1]), .err(o_err[1]), .err_count(o_ec[1]), .smp_count(o_sc[1]),
        .first_exp(o_fe[1]), .first_dut(o_fd[1]), .first_idx(o_fi[1]));

    counter_checker #(.LAT(2), .CNT_W(4)) u2 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .valid(valid),
        .exp_Q(exp_Q), .exp_rco(exp_rco), .dut_Q(dut_Q), .dut_rco(dut_rco),
        .state(o_st[2]), .err(o_err[2]), .err_count(ec2), .smp_count(sc2),
        .first_exp(o_fe[2]), .first_dut(o_fd[2]), .first_idx(fi2));

    int lat [3]  = '{0, 1, 2};
    int cmax [3] = '{255, 255, 15};

    int m_st [3], m_err [3], m_ec [3], m_sc [3], m_fe [3], m_fd [3], m_fi [3], m_ent [3];
    int cyc;
    logic [5:0] hist [$];
    int total, bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Window semantics: compare uses the sample taken LAT cycles ago, only if that sample arrived inside the window
    task automatic model(input int m);
        int t;
        logic [5:0] s;
        bit dv, mis;
        t = cyc;
        s = '0;
        dv = 0;
        mis = 0;
        if (reset) begin
            m_st[m] = 0; m_err[m] = 0; m_ec[m] = 0; m_sc[m] = 0;
            m_fe[m] = 0; m_fd[m] = 0; m_fi[m] = 0;
            return;
        end
        if (m_st[m] == 1 && t - lat[m] >= m_ent[m]) begin
            s = hist[t - lat[m]];
            dv = s[5];
            mis = dv && (s[4:0] != {dut_rco, dut_Q});
        end
        m_err[m] = mis;
        if (m_st[m] == 1) begin
            if (dv) begin
                if (mis && m_ec[m] == 0) begin
                    m_fe[m] = s[4:0];
                    m_fd[m] = {dut_rco, dut_Q};
                    m_fi[m] = m_sc[m];
                end
                if (mis) m_ec[m] = (m_ec[m] + 1 > cmax[m]) ? cmax[m] : m_ec[m] + 1;
                m_sc[m] = (m_sc[m] + 1 > cmax[m]) ? cmax[m] : m_sc[m] + 1;
            end
            if (stop) m_st[m] = (m_ec[m] == 0) ? 2 : 3;
        end else if (start) begin
            m_st[m] = 1; m_ec[m] = 0; m_sc[m] = 0;
            m_fe[m] = 0; m_fd[m] = 0; m_fi[m] = 0;
            m_ent[m] = t + 1;
        end
    endtask

    task automatic step();
        hist.push_back({valid, exp_rco, exp_Q});
        for (int m = 0; m < 3; m++) model(m);
        @(posedge clk);
        #1;
        cyc++;
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("c%0d_u%0d_state", cyc, m), o_st[m], m_st[m]);
            chk($sformatf("c%0d_u%0d_err", cyc, m), o_err[m], m_err[m]);
            chk($sformatf("c%0d_u%0d_err_count", cyc, m), o_ec[m], m_ec[m]);
            chk($sformatf("c%0d_u%0d_smp_count", cyc, m), o_sc[m], m_sc[m]);
            chk($sformatf("c%0d_u%0d_first_exp", cyc, m), o_fe[m], m_fe[m]);
            chk($sformatf("c%0d_u%0d_first_dut", cyc, m), o_fd[m], m_fd[m]);
            chk($sformatf("c%0d_u%0d_first_idx", cyc, m), o_fi[m], m_fi[m]);
        end
    endtask

    task automatic drv(input bit s, input bit p, input bit v, input logic [4:0] e, input logic [4:0] d);
        start = s;
        stop = p;
        valid = v;
        {exp_rco, exp_Q} = e;
        {dut_rco, dut_Q} = d;
        step();
    endtask

    initial begin
        logic [4:0] prev, e, d;
        total = 0;
        bad = 0;
        cyc = 0;
        for (int m = 0; m < 3; m++) m_ent[m] = 0;
        reset = 1'b1;
        drv(0, 0, 1, 5'h0, 5'h0);
        drv(1, 1, 1, 5'h3, 5'h4);
        reset = 1'b0;
        chk("reset_state", o_st[1], 2'b00);
        chk("reset_err_count", o_ec[1], 0);

        drv(0, 1, 0, 5'h0, 5'h0);
        chk("idle_ignores_stop", o_st[1], 2'b00);

        // clean window on the LAT=1 instance
        prev = 5'h0;
        drv(1, 0, 0, 5'h0, 5'h0);
        for (int i = 0; i < 10; i++) begin
            e = 5'($urandom_range(0, 31));
            drv(0, 0, 1, e, prev);
            prev = e;
        end
        drv(0, 1, 0, 5'h0, prev);
        chk("clean_state", o_st[1], 2'b10);
        chk("clean_smp_count", o_sc[1], 10);
        chk("clean_err_count", o_ec[1], 0);

        // single forced mismatch on the 4th compare
        prev = 5'h0;
        drv(1, 0, 0, 5'h0, 5'h0);
        for (int k = 0; k < 6; k++) begin
            d = (k == 4) ? 5'h05 : prev;
            drv(0, 0, 1, 5'(k), d);
            if (k == 4) chk("forced_err_pulse", o_err[1], 1);
            if (k == 5) chk("forced_err_single", o_err[1], 0);
            prev = 5'(k);
        end
        drv(0, 1, 0, 5'h0, prev);
        chk("forced_state", o_st[1], 2'b11);
        chk("forced_first_exp", o_fe[1], 5'h03);
        chk("forced_first_dut", o_fd[1], 5'h05);
        chk("forced_first_idx", o_fi[1], 3);

        // rco-only difference on the LAT=0 instance
        drv(1, 0, 0, 5'h0, 5'h0);
        drv(0, 0, 1, 5'h1F, 5'h0F);
        chk("rco_err_count", o_ec[0], 1);
        drv(0, 1, 0, 5'h0, 5'h0);
        chk("rco_state", o_st[0], 2'b11);
        chk("rco_first_exp", o_fe[0], 5'h1F);
        chk("rco_first_dut", o_fd[0], 5'h0F);

        // saturation on the 4-bit instance
        drv(1, 0, 0, 5'h0, 5'h0);
        for (int i = 0; i < 22; i++) drv(0, 0, 1, 5'h00, 5'h0F);
        drv(0, 1, 0, 5'h0, 5'h0F);
        chk("sat_err_count", o_ec[2], 15);
        chk("sat_smp_count", o_sc[2], 15);

        // start and stop together inside the window
        drv(1, 0, 0, 5'h0, 5'h0);
        chk("reenter_state", o_st[1], 2'b01);
        chk("reenter_smp_count", o_sc[1], 0);
        for (int i = 0; i < 3; i++) drv(0, 0, 1, 5'h0A, 5'h15);
        drv(1, 1, 0, 5'h0, 5'h15);
        chk("startstop_state", o_st[1], 2'b11);
        drv(1, 0, 0, 5'h0, 5'h0);
        chk("restart_state", o_st[1], 2'b01);
        chk("restart_err_count", o_ec[1], 0);
        chk("restart_first_idx", o_fi[1], 0);

        // reset in the middle of a failing window
        for (int i = 0; i < 3; i++) drv(0, 0, 1, 5'h00, 5'h0F);
        chk("midreset_pre_err_count", o_ec[1], 2);
        reset = 1'b1;
        drv(0, 0, 1, 5'h00, 5'h0F);
        reset = 1'b0;
        chk("midreset_state", o_st[1], 2'b00);
        chk("midreset_err_count", o_ec[1], 0);
        chk("midreset_smp_count", o_sc[1], 0);
        chk("midreset_err", o_err[1], 0);

        // random traffic
        prev = 5'h0;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            e = 5'($urandom_range(0, 31));
            d = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : prev;
            drv($urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, e, d);
            prev = e;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
